// File: rtl/otbn_otp_key_server.sv
// OTP key/nonce stand-in: LFSR-derived keys served to NUM_CH requesters over a
// 4-phase req/ack handshake with round-robin arbitration and a warm-up gate.
module otbn_otp_key_server #(
    parameter int unsigned         NUM_CH     = 2,
    parameter int unsigned         KEY_W      = 128,
    parameter int unsigned         NONCE_W    = 64,
    parameter logic [KEY_W-1:0]    KEY_TAPS   = 128'h87,
    parameter logic [NONCE_W-1:0]  NONCE_TAPS = 64'h1B,
    parameter logic [KEY_W-1:0]    KEY_SEED   = 128'h4235171482c225f79289b32181a0163a,
    parameter logic [NONCE_W-1:0]  NONCE_SEED = 64'h760355d3447063d1,
    parameter int unsigned         LATENCY    = 4,
    parameter int unsigned         WARMUP     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  req_i,
    output logic [NUM_CH-1:0]  ack_o,
    output logic [KEY_W-1:0]   key_o,
    output logic [NONCE_W-1:0] nonce_o,
    output logic               seed_valid_o,
    input  logic               ent_valid_i,
    input  logic [KEY_W-1:0]   ent_i,
    output logic               err_o
);

    // state | meaning
    // IDLE  | waiting for warm-up and a request; arbitrates round-robin
    // BUSY  | granted channel counting down LATENCY cycles
    // DONE  | ack held until the granted channel drops its request
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned WU_W  = $clog2(WARMUP + 1);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_lfsr_q, key_lfsr_d, key_step;
    logic [NONCE_W-1:0] nonce_lfsr_q, nonce_lfsr_d, nonce_step;
    logic [WU_W-1:0]    wu_cnt_q, wu_cnt_d;
    logic               seed_valid_q, seed_valid_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  ack_q, ack_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic               err_q, err_d;
    logic               arb_found;
    logic [PTR_W-1:0]   arb_idx;
    logic [PTR_W-1:0]   gnt_next;

    // All-zero next state would lock the LFSR, so the seed is reloaded instead.
    always_comb begin
        key_step     = {key_lfsr_q[KEY_W-2:0], ^(key_lfsr_q & KEY_TAPS)} ^ (ent_valid_i ? ent_i : '0);
        key_lfsr_d   = (key_step == '0) ? KEY_SEED : key_step;
        nonce_step   = {nonce_lfsr_q[NONCE_W-2:0], ^(nonce_lfsr_q & NONCE_TAPS)};
        nonce_lfsr_d = (nonce_step == '0) ? NONCE_SEED : nonce_step;
        wu_cnt_d     = (wu_cnt_q == WU_W'(WARMUP)) ? wu_cnt_q : wu_cnt_q + 1'b1;
        seed_valid_d = seed_valid_q | (wu_cnt_d == WU_W'(WARMUP));
    end

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
            if (req_i[PTR_W'(idx)]) begin
                arb_found = 1'b1;
                arb_idx   = PTR_W'(idx);
            end
        end
    end

    assign gnt_next = (gnt_q == PTR_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        ack_d    = ack_q;
        key_d    = key_q;
        nonce_d  = nonce_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (seed_valid_q && arb_found) begin
                    gnt_d   = arb_idx;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Abort still advances the pointer so a flaky requester cannot starve others.
                if (!req_i[gnt_q]) begin
                    err_d    = 1'b1;
                    rr_ptr_d = gnt_next;
                    state_d  = IDLE;
                end else if (cnt_q == '0) begin
                    key_d    = key_lfsr_q;
                    nonce_d  = nonce_lfsr_q;
                    ack_d    = NUM_CH'(1) << gnt_q;
                    rr_ptr_d = gnt_next;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (!req_i[gnt_q]) begin
                    ack_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            key_lfsr_q   <= KEY_SEED;
            nonce_lfsr_q <= NONCE_SEED;
            wu_cnt_q     <= '0;
            seed_valid_q <= 1'b0;
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            cnt_q        <= '0;
            ack_q        <= '0;
            key_q        <= '0;
            nonce_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_lfsr_q   <= key_lfsr_d;
            nonce_lfsr_q <= nonce_lfsr_d;
            wu_cnt_q     <= wu_cnt_d;
            seed_valid_q <= seed_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            gnt_q        <= gnt_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            key_q        <= key_d;
            nonce_q      <= nonce_d;
            err_q        <= err_d;
        end
    end

    assign ack_o        = ack_q;
    assign key_o        = key_q;
    assign nonce_o      = nonce_q;
    assign seed_valid_o = seed_valid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_otbn_otp_key_server.sv
// Bench for otbn_otp_key_server: reference LFSR model with per-cycle history and
// a scoreboard of expected (channel, ack edge) pairs checked by an ack monitor.
module tb_otbn_otp_key_server;

    localparam int NUM_CH  = 2;
    localparam int KEY_W   = 128;
    localparam int NONCE_W = 64;
    localparam int LAT     = 4;
    localparam logic [KEY_W-1:0]   KEY_TAPS   = 128'h87;
    localparam logic [NONCE_W-1:0] NONCE_TAPS = 64'h1B;
    localparam logic [KEY_W-1:0]   KEY_SEED   = 128'h4235171482c225f79289b32181a0163a;
    localparam logic [NONCE_W-1:0] NONCE_SEED = 64'h760355d3447063d1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_CH-1:0]  req_i = '0;
    logic [NUM_CH-1:0]  ack_o;
    logic [KEY_W-1:0]   key_o;
    logic [NONCE_W-1:0] nonce_o;
    logic               seed_valid_o;
    logic               ent_valid_i = 1'b0;
    logic [KEY_W-1:0]   ent_i = '0;
    logic               err_o;

    otbn_otp_key_server dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .ack_o        (ack_o),
        .key_o        (key_o),
        .nonce_o      (nonce_o),
        .seed_valid_o (seed_valid_o),
        .ent_valid_i  (ent_valid_i),
        .ent_i        (ent_i),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; int edge_n;} exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [KEY_W-1:0]   m_key   = KEY_SEED;
    logic [NONCE_W-1:0] m_nonce = NONCE_SEED;
    logic [KEY_W-1:0]   key_hist [int];
    logic [NONCE_W-1:0] nonce_hist [int];
    logic [KEY_W-1:0]   first_key;
    logic [NUM_CH-1:0]  prev_ack = '0;

    function automatic logic [KEY_W-1:0] key_shift(input logic [KEY_W-1:0] k);
        return {k[KEY_W-2:0], ^(k & KEY_TAPS)};
    endfunction

    function automatic logic [KEY_W-1:0] key_next(input logic [KEY_W-1:0] k, input logic ev,
                                                  input logic [KEY_W-1:0] e);
        logic [KEY_W-1:0] n;
        n = key_shift(k) ^ (ev ? e : '0);
        return (n == '0) ? KEY_SEED : n;
    endfunction

    function automatic logic [NONCE_W-1:0] nonce_next(input logic [NONCE_W-1:0] k);
        logic [NONCE_W-1:0] n;
        n = {k[NONCE_W-2:0], ^(k & NONCE_TAPS)};
        return (n == '0) ? NONCE_SEED : n;
    endfunction

    // Reference model: history[e] holds the LFSR value present just before edge e.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_key   = KEY_SEED;
            m_nonce = NONCE_SEED;
            cyc     = 0;
        end else begin
            cyc = cyc + 1;
            key_hist[cyc]   = m_key;
            nonce_hist[cyc] = m_nonce;
            m_key   = key_next(m_key, ent_valid_i, ent_i);
            m_nonce = nonce_next(m_nonce);
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_ack = '0;
        end else begin
            n_checks++;
            if ($countones(ack_o) > 1) $display("FAIL ack_onehot: got %b want at most one bit", ack_o);
            else n_pass++;
            if (ack_o != '0 && prev_ack == '0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ack: got %b at cycle %0d want none", ack_o, cyc);
                end else begin
                    exp_t e;
                    logic [NUM_CH-1:0] ea;
                    e = sb.pop_front();
                    ea = '0;
                    ea[e.ch] = 1'b1;
                    n_checks++;
                    if (ack_o !== ea || cyc !== e.edge_n)
                        $display("FAIL ack_timing: got %b at cycle %0d want %b at cycle %0d", ack_o, cyc, ea, e.edge_n);
                    else n_pass++;
                    n_checks++;
                    if (key_o !== key_hist[cyc] || nonce_o !== nonce_hist[cyc])
                        $display("FAIL ack_data: got %h/%h want %h/%h", key_o, nonce_o, key_hist[cyc], nonce_hist[cyc]);
                    else n_pass++;
                end
            end
            prev_ack = ack_o;
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ack_o !== '0 || key_o !== '0 || nonce_o !== '0 || seed_valid_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL reset_values: got ack=%b key=%h nonce=%h sv=%b err=%b want all 0",
                     ack_o, key_o, nonce_o, seed_valid_o, err_o);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_first_ack(input bit after_reset);
        wait_to(2);
        req_i = 2'b01;
        sb.push_back('{0, 21});
        wait_to(15);
        n_checks++;
        if (seed_valid_o !== 1'b0) $display("FAIL warmup_low: got %b at cycle 15 want 0", seed_valid_o);
        else n_pass++;
        wait_to(16);
        n_checks++;
        if (seed_valid_o !== 1'b1) $display("FAIL warmup_high: got %b at cycle 16 want 1", seed_valid_o);
        else n_pass++;
        wait_to(20);
        n_checks++;
        if (ack_o !== 2'b00) $display("FAIL ack_early: got %b at cycle 20 want 00", ack_o);
        else n_pass++;
        wait_to(21);
        n_checks++;
        if (ack_o !== 2'b01 || key_o == '0 || nonce_o == '0)
            $display("FAIL first_ack: got ack=%b key=%h nonce=%h want ack=01 nonzero data", ack_o, key_o, nonce_o);
        else n_pass++;
        if (after_reset) begin
            n_checks++;
            if (key_o !== first_key) $display("FAIL reboot_key: got %h want %h", key_o, first_key);
            else n_pass++;
        end else begin
            first_key = key_o;
        end
        req_i = 2'b00;
        @(negedge clk);
        n_checks++;
        if (ack_o !== 2'b00) $display("FAIL ack_release: got %b want 00", ack_o);
        else n_pass++;
    endtask

    task automatic test_round_robin;
        int ch;
        int g;
        logic [KEY_W-1:0] prev_key;
        ch = 1;
        prev_key = first_key;
        req_i = 2'b11;
        for (int k = 0; k < 3; k++) begin
            g = cyc + 1;
            sb.push_back('{ch, g + LAT});
            wait_to(g + LAT);
            n_checks++;
            if (ack_o[ch] !== 1'b1 || key_o === prev_key)
                $display("FAIL rr_grant%0d: got ack=%b key=%h want ch%0d with new key", k, ack_o, key_o, ch);
            else n_pass++;
            prev_key = key_o;
            if (k < 2) begin
                req_i[ch] = 1'b0;
                @(negedge clk);
                n_checks++;
                if (ack_o !== 2'b00) $display("FAIL rr_release%0d: got %b want 00", k, ack_o);
                else n_pass++;
                req_i[ch] = 1'b1;
                ch = 1 - ch;
            end else begin
                req_i = 2'b00;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_abort;
        int c;
        int pulses;
        logic err_at;
        bit ack_bad;
        bit key_bad;
        logic [KEY_W-1:0] kb;
        c = cyc;
        kb = key_o;
        req_i = 2'b11;
        wait_to(c + 3);
        req_i = 2'b10;
        sb.push_back('{1, c + 9});
        pulses = 0;
        ack_bad = 1'b0;
        key_bad = 1'b0;
        err_at = 1'b0;
        for (int t = 4; t <= 8; t++) begin
            @(negedge clk);
            if (err_o) pulses++;
            if (t == 4) err_at = err_o;
            if (ack_o !== 2'b00) ack_bad = 1'b1;
            if (key_o !== kb) key_bad = 1'b1;
        end
        @(negedge clk);
        if (err_o) pulses++;
        n_checks++;
        if (err_at !== 1'b1 || pulses != 1) $display("FAIL abort_err: got pulses=%0d first=%b want 1/1", pulses, err_at);
        else n_pass++;
        n_checks++;
        if (ack_bad) $display("FAIL abort_noack: got an ack during abort window want none");
        else n_pass++;
        n_checks++;
        if (key_bad) $display("FAIL abort_key: got changed key want %h", kb);
        else n_pass++;
        n_checks++;
        if (ack_o !== 2'b10) $display("FAIL abort_pending: got %b want 10", ack_o);
        else n_pass++;
        req_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_entropy;
        int c;
        c = cyc;
        req_i = 2'b01;
        sb.push_back('{0, c + 5});
        wait_to(c + 3);
        ent_valid_i = 1'b1;
        ent_i = key_shift(m_key);
        @(negedge clk);
        ent_valid_i = 1'b0;
        ent_i = '0;
        wait_to(c + 5);
        n_checks++;
        if (ack_o !== 2'b01 || key_o !== KEY_SEED)
            $display("FAIL lockup_reload: got ack=%b key=%h want 01/%h", ack_o, key_o, KEY_SEED);
        else n_pass++;
        req_i = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_hold;
        int c;
        logic [KEY_W-1:0] kh;
        logic [NONCE_W-1:0] nh;
        c = cyc;
        req_i = 2'b01;
        sb.push_back('{0, c + 5});
        wait_to(c + 5);
        kh = key_o;
        nh = nonce_o;
        for (int t = 0; t < 10; t++) begin
            ent_valid_i = 1'($urandom_range(0, 1));
            ent_i = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            n_checks++;
            if (ack_o !== 2'b01 || key_o !== kh || nonce_o !== nh)
                $display("FAIL hold%0d: got ack=%b key=%h want 01/%h", t, ack_o, key_o, kh);
            else n_pass++;
        end
        ent_valid_i = 1'b0;
        ent_i = '0;
        req_i = 2'b00;
        @(negedge clk);
        n_checks++;
        if (ack_o !== 2'b00) $display("FAIL hold_release: got %b want 00", ack_o);
        else n_pass++;
    endtask

    task automatic test_reset_busy;
        int c;
        c = cyc;
        req_i = 2'b01;
        wait_to(c + 2);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ack_o !== '0 || key_o !== '0 || nonce_o !== '0 || seed_valid_o !== 1'b0 || err_o !== 1'b0)
            $display("FAIL async_reset: got ack=%b key=%h nonce=%h sv=%b err=%b want all 0",
                     ack_o, key_o, nonce_o, seed_valid_o, err_o);
        else n_pass++;
        req_i = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_first_ack(1'b1);
    endtask

    initial begin
        test_reset();
        test_first_ack(1'b0);
        test_round_robin();
        test_abort();
        test_entropy();
        test_hold();
        test_reset_busy();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
